input_window_scheduler: RTL
===========================

INPUT_WINDOW_SCHEDULER -- requirements
Module: input_window_scheduler

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_FIFOS, 3: number of sub-input FIFOs read in lockstep, one per kernel row.
- READ_PORTS, 3: words returned per FIFO read.
- POINTER_WIDTH, 5: FIFO pointer width; each element count is POINTER_WIDTH+1 bits.
- INPUT_COL_WIDTH, 6: column-count width.
- ROW_WIDTH, 6: output-row-count width.
- CHANNEL_WIDTH, 11: channel-count width.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- i_clock, in, 1: single clock; all state updates on the rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_start, in, 1: start pulse; configuration is latched when accepted.
- i_abort, in, 1: terminate the current job.
- i_output_size, in, INPUT_COL_WIDTH: output columns per row.
- i_output_rows, in, ROW_WIDTH: output rows per channel.
- i_num_channels, in, CHANNEL_WIDTH: channels per job.
- i_element_count, in, NUM_FIFOS*(POINTER_WIDTH+1): packed FIFO fill levels, FIFO 0 in the LSBs.
- i_downstream_ready, in, 1: consumer can accept a window.
- o_renable, out, 1: read enable broadcast to all FIFOs.
- o_valid_read_count, out, INPUT_COL_WIDTH: read index within the current row.
- o_output_size, out, INPUT_COL_WIDTH: latched i_output_size.
- o_row_count, out, ROW_WIDTH: current output row.
- o_channel_count, out, CHANNEL_WIDTH: current channel.
- o_busy, out, 1: job in progress.
- o_done, out, 1: single-cycle job-complete pulse.
- o_cfg_error, out, 1: single-cycle pulse on a rejected start.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, DONE.

REQ-004 IDLE->RUN SHALL occur on i_start=1 when i_output_size>=2, i_output_rows!=0 and i_num_channels!=0; the three configuration values SHALL be latched on that edge and all counters cleared to 0.

REQ-005 If i_start=1 in IDLE with an invalid configuration, the FSM SHALL stay in IDLE and o_cfg_error SHALL pulse high for one cycle.

REQ-006 i_start SHALL be ignored in RUN and DONE.

REQ-007 o_renable SHALL be combinational (zero latency) and equal to (state==RUN) AND (every i_element_count slice >= READ_PORTS) AND i_downstream_ready AND NOT i_abort.

REQ-008 o_valid_read_count SHALL be registered and hold the index of the read currently being issued; it increments by 1 on each edge where o_renable=1.

REQ-009 On an edge where o_renable=1 and o_valid_read_count == latched output_size-2, o_valid_read_count SHALL wrap to 0 and o_row_count SHALL increment by 1. The FIFO applies its 3-word row skip on the same read.

REQ-010 When a row wrap occurs with o_row_count == rows-1, o_row_count SHALL clear to 0 and o_channel_count SHALL increment by 1.

REQ-011 When a row wrap occurs with o_row_count == rows-1 and o_channel_count == channels-1, the FSM SHALL go to DONE and all counters SHALL clear to 0.

REQ-012 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE.

REQ-013 Any single FIFO below READ_PORTS, or i_downstream_ready=0, SHALL stall the schedule: o_renable=0 and all counters hold, with no limit on stall length.

REQ-014 i_abort=1 in RUN SHALL force o_renable=0 in that cycle, go to IDLE on the next edge, clear all counters, and SHALL NOT pulse o_done. i_abort in IDLE or DONE SHALL have no effect.

REQ-015 o_busy SHALL be 1 exactly when state==RUN.

REQ-016 All counter comparisons SHALL use the latched configuration only; changes to i_output_size, i_output_rows or i_num_channels during RUN SHALL have no effect.

REQ-017 Total reads per job SHALL equal (output_size-1)*rows*channels, with counters at full width and no overflow for any legal configuration.

Reset
REQ-018 With i_reset=1 at a rising edge, the block SHALL enter IDLE, and o_valid_read_count, o_output_size, o_row_count, o_channel_count, o_busy, o_done and o_cfg_error SHALL all be 0.

REQ-019 o_renable SHALL be 0 during reset and in the cycle after reset release; reset asserted mid-RUN SHALL discard the job without an o_done pulse.

Verification
REQ-020 Nominal job: size=4, rows=2, channels=1, all counts=8, ready=1 -> o_renable high for 6 consecutive cycles; o_valid_read_count sequence 0,1,2,0,1,2; o_row_count steps 0->1; o_done pulses on the 7th cycle after the start edge.

REQ-021 Starvation: FIFO 1 count=2 while the others are 8 -> o_renable=0 and counters hold; raise FIFO 1 count to 3 -> o_renable=1 in the same cycle.

REQ-022 Backpressure: de-assert i_downstream_ready for 5 cycles mid-row at count=1 -> no reads during those cycles; resumes at count=1; total reads still 6.

REQ-023 Channel rollover: size=3, rows=1, channels=3 -> o_channel_count steps 0,1,2; 6 reads total, then o_done.

REQ-024 Config error and abort: start with size=1 -> o_cfg_error pulse, stays IDLE. Abort at row 1 -> IDLE next cycle, counters 0, no o_done.

REQ-025 Reset mid-RUN: i_reset=1 during row 0 -> all outputs 0; a new i_start after release runs a full job correctly.

Source files
------------

// File: rtl/input_window_scheduler.sv
// Read scheduler for a bank of row FIFOs feeding a sliding-window kernel.
// Walks column/row/channel counters and broadcasts a read enable when every FIFO can supply a full read.
//
// state | meaning
// IDLE  | waiting for a valid start; configuration latched on acceptance
// RUN   | issuing reads whenever all FIFOs are filled and downstream is ready
// DONE  | one-cycle job-complete pulse, then back to IDLE
module input_window_scheduler #(
  parameter int NUM_FIFOS       = 3,
  parameter int READ_PORTS      = 3,
  parameter int POINTER_WIDTH   = 5,
  parameter int INPUT_COL_WIDTH = 6,
  parameter int ROW_WIDTH       = 6,
  parameter int CHANNEL_WIDTH   = 11
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_start,
  input  logic                                     i_abort,
  input  logic [INPUT_COL_WIDTH-1:0]               i_output_size,
  input  logic [ROW_WIDTH-1:0]                     i_output_rows,
  input  logic [CHANNEL_WIDTH-1:0]                 i_num_channels,
  input  logic [NUM_FIFOS*(POINTER_WIDTH+1)-1:0]   i_element_count,
  input  logic                                     i_downstream_ready,
  output logic                                     o_renable,
  output logic [INPUT_COL_WIDTH-1:0]               o_valid_read_count,
  output logic [INPUT_COL_WIDTH-1:0]               o_output_size,
  output logic [ROW_WIDTH-1:0]                     o_row_count,
  output logic [CHANNEL_WIDTH-1:0]                 o_channel_count,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_cfg_error
);

  localparam int CW = POINTER_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state, state_nxt;
  logic [INPUT_COL_WIDTH-1:0]  size_q, rd_q;
  logic [ROW_WIDTH-1:0]        rows_q, row_q;
  logic [CHANNEL_WIDTH-1:0]    chans_q, ch_q;
  logic                        cfg_err_q;
  logic                        cfg_ok, fifos_ok, start_ok;
  logic                        row_wrap, ch_wrap, last_read;

  // A single starved FIFO stalls the whole lockstep read.
  always_comb begin
    fifos_ok = 1'b1;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (i_element_count[i*CW +: CW] < CW'(READ_PORTS)) fifos_ok = 1'b0;
    end
  end

  assign cfg_ok   = (i_output_size >= INPUT_COL_WIDTH'(2)) &&
                    (i_output_rows != '0) && (i_num_channels != '0);
  assign start_ok = (state == S_IDLE) && i_start && cfg_ok;

  // A row holds size-1 reads; the last one also triggers the FIFO row skip.
  assign row_wrap  = o_renable && (rd_q == size_q - INPUT_COL_WIDTH'(2));
  assign ch_wrap   = row_wrap && (row_q == rows_q - ROW_WIDTH'(1));
  assign last_read = ch_wrap && (ch_q == chans_q - CHANNEL_WIDTH'(1));

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (i_abort) state_nxt = S_IDLE;
               else if (last_read) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_renable = (state == S_RUN) && fifos_ok && i_downstream_ready && !i_abort && !i_reset;
    o_busy    = (state == S_RUN);
    o_done    = (state == S_DONE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      size_q    <= '0;
      rows_q    <= '0;
      chans_q   <= '0;
      rd_q      <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == S_IDLE) && i_start && !cfg_ok;
      if (start_ok) begin
        size_q  <= i_output_size;
        rows_q  <= i_output_rows;
        chans_q <= i_num_channels;
        rd_q    <= '0;
        row_q   <= '0;
        ch_q    <= '0;
      end else if (state == S_RUN && i_abort) begin
        rd_q  <= '0;
        row_q <= '0;
        ch_q  <= '0;
      end else if (o_renable) begin
        if (row_wrap) begin
          rd_q <= '0;
          if (ch_wrap) begin
            row_q <= '0;
            ch_q  <= last_read ? '0 : ch_q + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          rd_q <= rd_q + 1'b1;
        end
      end
    end
  end

  assign o_valid_read_count = rd_q;
  assign o_output_size      = size_q;
  assign o_row_count        = row_q;
  assign o_channel_count    = ch_q;
  assign o_cfg_error        = cfg_err_q;

endmodule
